// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state and stride-mode types for the convolution controller
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STREAM, CONV} state_t;
  typedef enum logic {STRIDE1, STRIDE2} conv_mode_t;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: wrapping up-counter 0..rollover_val
//   clk, n_rst (async active-low), clear (sync to 0), count_enable,
//   rollover_val, count_out, rollover_flag (high while count_out == rollover_val)
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  assign rollover_flag = count_out == rollover_val;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count_out <= '0;
    else if (clear) count_out <= '0;
    else if (count_enable) count_out <= rollover_flag ? '0 : count_out + 1'b1;
endmodule

// File: rtl/param_conv_controller.sv
// param_conv_controller: sequences coefficient load, row shift, sample streaming and KxK convolution
//   in : clk, n_rst (async active-low), coeff_load_en, new_row, stride2, sample_load_en
//   out: modwait, coeff_ld, coeff_sel, sample_shift, sample_stream, convolve_en, row_done, err
module param_conv_controller
  import conv_pkg::*;
#(
  parameter int K         = 3,
  parameter int IMG_WIDTH = 16,
  localparam int SEL_W    = $clog2(K),
  localparam int CNT_W    = $clog2(IMG_WIDTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             coeff_load_en,
  input  logic             new_row,
  input  logic             stride2,
  input  logic             sample_load_en,
  output logic             modwait,
  output logic             coeff_ld,
  output logic [SEL_W-1:0] coeff_sel,
  output logic             sample_shift,
  output logic             sample_stream,
  output logic             convolve_en,
  output logic             row_done,
  output logic             err
);
  localparam logic KODD = (K % 2) == 1;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  col_cnt_q, col_cnt_d, col_new;
  logic              coeff_valid_q, coeff_valid_d, err_q, err_d;
  conv_mode_t        stride_q, stride_d;
  logic [SEL_W-1:0]  sel;
  logic              sel_last, seq_en, idle, row_full, acc_cl, acc_nr, acc_sl, win_ok;

  assign seq_en = state_q == LOAD || state_q == CONV;

  flex_counter #(.NUM_CNT_BITS(SEL_W)) u_sel_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!seq_en),
    .count_enable (seq_en),
    .rollover_val (SEL_W'(K - 1)),
    .count_out    (sel),
    .rollover_flag(sel_last)
  );

  always_comb begin
    idle     = state_q == IDLE;
    row_full = col_cnt_q == CNT_W'(IMG_WIDTH);
    col_new  = col_cnt_q + 1'b1;
    acc_cl   = idle && coeff_load_en;
    acc_nr   = idle && !coeff_load_en && new_row;
    acc_sl   = idle && !coeff_load_en && !new_row && sample_load_en && coeff_valid_q && !row_full;
    // (col_new - K) is even exactly when col_new and K share parity
    win_ok   = col_new >= CNT_W'(K) && (stride_q == STRIDE1 || col_new[0] == KODD);
    // any request while busy, or an idle sample that is dropped or rejected, flags an error
    err_d    = acc_nr ? 1'b0
             : err_q | (!idle && (coeff_load_en || new_row || sample_load_en))
                     | (idle && sample_load_en && !acc_sl);
    coeff_valid_d = coeff_valid_q | (state_q == LOAD && sel_last);
    stride_d  = acc_nr ? conv_mode_t'(stride2) : stride_q;
    col_cnt_d = state_q == SHIFT ? '0 : state_q == STREAM ? col_new : col_cnt_q;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = acc_cl ? LOAD : acc_nr ? SHIFT : acc_sl ? STREAM : IDLE;
      LOAD:    state_d = sel_last ? IDLE : LOAD;
      SHIFT:   state_d = IDLE;
      STREAM:  state_d = win_ok ? CONV : IDLE;
      CONV:    state_d = sel_last ? IDLE : CONV;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q       <= IDLE;
      col_cnt_q     <= '0;
      coeff_valid_q <= 1'b0;
      stride_q      <= STRIDE1;
      err_q         <= 1'b0;
      modwait       <= 1'b0;
      coeff_ld      <= 1'b0;
      coeff_sel     <= '0;
      sample_shift  <= 1'b0;
      sample_stream <= 1'b0;
      convolve_en   <= 1'b0;
      row_done      <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      coeff_valid_q <= coeff_valid_d;
      stride_q      <= stride_d;
      err_q         <= err_d;
      // outputs are a registered Moore decode of the current state
      modwait       <= !idle;
      coeff_ld      <= state_q == LOAD;
      coeff_sel     <= seq_en ? sel : '0;
      sample_shift  <= state_q == SHIFT;
      sample_stream <= state_q == STREAM;
      convolve_en   <= state_q == CONV;
      row_done      <= state_q == STREAM && col_new == CNT_W'(IMG_WIDTH);
    end

  assign err = err_q;
endmodule

// File: tb/tb_param_conv_controller.sv
// tb_param_conv_controller: scoreboard bench with a transaction-level reference model
module tb_param_conv_controller;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int SW = $clog2(K);
  typedef logic [4+SW:0] exp_t;

  logic clk = 0, n_rst = 0, cl = 0, nr = 0, st = 0, sl = 0;
  logic modwait, coeff_ld, sample_shift, sample_stream, convolve_en, row_done, err;
  logic [SW-1:0] coeff_sel;

  param_conv_controller #(.K(K), .IMG_WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst), .coeff_load_en(cl), .new_row(nr), .stride2(st),
    .sample_load_en(sl), .modwait(modwait), .coeff_ld(coeff_ld), .coeff_sel(coeff_sel),
    .sample_shift(sample_shift), .sample_stream(sample_stream), .convolve_en(convolve_en),
    .row_done(row_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  exp_t q[$];
  bit m_cv = 0, m_st = 0, m_err = 0;
  int m_col = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [3:0] v, int s, bit rd);
    return {v, SW'(s), rd};
  endfunction

  // monitor: every cycle with an active strobe must match the next expected event
  always @(negedge clk) begin
    exp_t a;
    a = {coeff_ld, sample_shift, sample_stream, convolve_en, coeff_sel, row_done};
    if (n_rst && (coeff_ld | sample_shift | sample_stream | convolve_en)) begin
      if (q.size() == 0) chk("unexpected_out", 32'(a), 0);
      else begin
        chk("out_seq", 32'(a), 32'(q.pop_front()));
        chk("busy_modwait", 32'(modwait), 1);
      end
    end
  end

  // reference model: outcome of one request issued while the controller is idle
  task automatic model(bit c, bit n, bit s, bit l);
    if (c) begin
      for (int i = 0; i < K; i++) q.push_back(mk(4'b1000, i, 0));
      m_cv = 1;
      if (l) m_err = 1;
    end else if (n) begin
      q.push_back(mk(4'b0100, 0, 0));
      m_col = 0;
      m_st = s;
      m_err = 0;
    end else if (l) begin
      if (!m_cv || m_col == W) m_err = 1;
      else begin
        m_col++;
        q.push_back(mk(4'b0010, 0, m_col == W));
        if (m_col >= K && (!m_st || (m_col - K) % 2 == 0))
          for (int i = 0; i < K; i++) q.push_back(mk(4'b0001, i, 0));
      end
    end
  endtask

  task automatic op(bit c, bit n, bit s, bit l);
    @(negedge clk); cl = c; nr = n; st = s; sl = l;
    @(negedge clk); cl = 0; nr = 0; st = 0; sl = 0;
    model(c, n, s, l);
  endtask

  task automatic settle(string name);
    repeat (K + 5) @(negedge clk);
    chk({name, "_err"}, 32'(err), 32'(m_err));
    chk({name, "_idle"}, 32'(modwait), 0);
    chk({name, "_drained"}, q.size(), 0);
    q.delete();
  endtask

  task automatic row(bit s, int n);
    op(0, 1, s, 0); settle("new_row");
    for (int i = 0; i < n; i++) begin op(0, 0, 0, 1); settle("sample"); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({modwait, coeff_ld, coeff_sel, sample_shift, sample_stream,
                           convolve_en, row_done, err}), 0);
    n_rst = 1;
    op(0, 0, 0, 1); settle("early_sample");
    op(1, 0, 0, 0); settle("coeff_load");
    row(0, W);
    op(0, 0, 0, 1); settle("overflow");
    row(1, W);
    row(0, 2);
    op(0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk); sl = 1;
    @(negedge clk); sl = 0;
    m_err = 1;
    settle("overrun_conv");
    op(1, 0, 0, 1); settle("priority");
    op(0, 1, 0, 0); settle("clear");
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) op(1, 0, 0, 0);
      else if (r == 1) op(0, 1, 1'($urandom_range(0, 1)), 0);
      else if (r == 2) op(1, 0, 0, 1);
      else if (r == 3) op(0, 1, 1'($urandom_range(0, 1)), 1);
      else if (r == 4) op(1, 1, 0, 0);
      else op(0, 0, 0, 1);
      settle("rand");
    end
    row(0, 2);
    op(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #2 n_rst = 0;
    #1 chk("reset_mid_conv", 32'({modwait, coeff_ld, coeff_sel, sample_shift, sample_stream,
                                   convolve_en, row_done, err}), 0);
    q.delete();
    m_cv = 0; m_col = 0; m_st = 0; m_err = 0;
    @(negedge clk); n_rst = 1;
    @(negedge clk);
    chk("post_reset_err", 32'(err), 0);
    chk("post_reset_idle", 32'(modwait), 0);
    op(0, 0, 0, 1); settle("post_reset_no_coeff");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
